// File: rtl/stack_param.sv
// stack_param: parameterised LIFO stack with occupancy count, top-of-stack
// peek, push+pop replace, sticky overflow/underflow flags and clock enable.
// Optional build macro STACK_EDGE_DETECT_EN: push/pop act only on a rising
// edge sampled on enabled clocks (one operation per button press).
module stack_param #(
   parameter int  DATA_WIDTH = 4,
   parameter int  DEPTH      = 8,
   localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  clr_err,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  empty,
   output logic                  full,
   output logic [CNT_WIDTH-1:0]  count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  do_push, do_pop;
   logic                  wr_en;
   logic [IDX_W-1:0]      wr_idx;
   logic [IDX_W-1:0]      nxt_idx, top_idx, below_idx;

   // count doubles as the stack pointer (next free slot)
   assign empty     = (count == '0);
   assign full      = (count == CNT_WIDTH'(DEPTH));
   assign nxt_idx   = IDX_W'(count);
   assign top_idx   = IDX_W'(count - CNT_WIDTH'(1));
   assign below_idx = IDX_W'(count - CNT_WIDTH'(2));

`ifdef STACK_EDGE_DETECT_EN
   logic push_q, pop_q;

   // remember last sampled request level so a held button acts once
   always_ff @(posedge clk) begin
      if (reset) begin
         push_q <= 1'b0;
         pop_q  <= 1'b0;
      end else if (en) begin
         push_q <= push;
         pop_q  <= pop;
      end
   end

   assign do_push = push & ~push_q;
   assign do_pop  = pop  & ~pop_q;
`else
   assign do_push = push;
   assign do_pop  = pop;
`endif

   // pick the storage write: replace top on push+pop, else append if room
   always_comb begin
      wr_en  = 1'b0;
      wr_idx = nxt_idx;
      if (en && !reset && do_push) begin
         if (do_pop && !empty) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
         end else if (!full) begin
            wr_en = 1'b1;
         end
      end
   end

   // storage array, intentionally not reset
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= push_data;
   end

   // pointer, peek register and sticky flags; a new error beats clr_err
   always_ff @(posedge clk) begin
      if (reset) begin
         count     <= '0;
         pop_data  <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (en) begin
         if (clr_err) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end
         if (do_push && do_pop && !empty) begin
            pop_data <= push_data;
         end else if (do_push) begin
            if (!full) begin
               count    <= count + CNT_WIDTH'(1);
               pop_data <= push_data;
            end else begin
               overflow <= 1'b1;
            end
         end else if (do_pop) begin
            if (!empty) begin
               count    <= count - CNT_WIDTH'(1);
               pop_data <= (count >= CNT_WIDTH'(2)) ? mem[below_idx] : '0;
            end else begin
               underflow <= 1'b1;
            end
         end
      end
   end

endmodule
